decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 fetch_instr  in  32  instruction from fetch stage.
REQ-004 pc  in  32  PC of fetch_instr.
REQ-005 clk_en  in  1  fetch stage holds a valid instruction (fetch next_clk_en).
REQ-006 stall  in  1  downstream stall; hold all decode state.
REQ-007 flush  in  1  kill the instruction entering decode.
REQ-008 decode_pc  out  32  registered PC of decoded instruction.
REQ-009 decode_opcode  out  7  instr[6:0].
REQ-010 decode_funct3  out  3  instr[14:12].
REQ-011 decode_funct7_b5  out  1  instr[30].
REQ-012 decode_rs1_addr / decode_rs2_addr / decode_rd_addr  out  5 each  register indices.
REQ-013 decode_imm  out  32  sign-extended immediate.
REQ-014 decode_illegal  out  1  illegal-instruction flag.
REQ-015 next_clk_en  out  1  decode outputs valid for execute.
REQ-016 decode_stall_req  out  1  combinational request for fetch to hold (load-use).

Function
REQ-017 Latency: one cycle from fetch_instr/clk_en to all decode_* outputs.
REQ-018 Capture when clk_en=1, stall=0, flush=0, hazard=0: load all fields, next_clk_en<=1.
REQ-019 stall=1 and flush=0: every output register holds, next_clk_en included.
REQ-020 flush=1: next_clk_en<=0 regardless of stall/clk_en/hazard; field registers hold; flush has top priority.
REQ-021 clk_en=0, stall=0, flush=0: next_clk_en<=0 (bubble); fields hold.
REQ-022 Hazard = next_clk_en=1 AND decode_opcode=LOAD AND decode_rd_addr!=0 AND clk_en=1 AND rd equals a used source of fetch_instr (rs1 for JALR/BRANCH/LOAD/STORE/OP_IMM/OP; rs2 for BRANCH/STORE/OP).
REQ-023 decode_stall_req = hazard AND NOT flush; on hazard, next_clk_en<=0 and fetch_instr is not captured; exactly one bubble per load-use pair.
REQ-024 Immediate by opcode: I (LOAD, OP_IMM, JALR, SYSTEM), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); all sign-extend from instr[31]; other opcodes give 0.
REQ-025 decode_rd_addr forced 0 for STORE, BRANCH, FENCE and illegal instructions.
REQ-026 decode_rs1_addr/decode_rs2_addr forced 0 when that source is unused per REQ-022.
REQ-027 Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM; instr[1:0]!=2'b11 is illegal.

Reset
REQ-028 rst=1 immediately (no clock edge) forces every output register to 0, including next_clk_en and decode_illegal.
REQ-029 While rst=1, decode_stall_req=0; first capture occurs on the first rising edge after rst deasserts with clk_en=1.

Configuration
REQ-030 Macro DECODE_ILLEGAL_TRAP_EN defined: decode_illegal registered per REQ-027, updated under the same rules as the other fields.
REQ-031 Macro undefined: decode_illegal tied 0, no illegal-detect logic; REQ-025 rd forcing for illegal opcodes still applies.

Structure
REQ-032 Shared package rv32i_pkg holds the 7-bit opcode constants and an immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
REQ-033 One combinational sub-module imm_gen (instr -> imm) is instantiated; hazard and pipeline registers live in decode_stage.

Verification
REQ-034 ADDI x1,x0,5 (0x00500093), clk_en=1 -> next cycle: rd=1, rs1=0, rs2=0, imm=0x00000005, opcode=0x13, next_clk_en=1.
REQ-035 BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, rd=0, funct3=0, next_clk_en=1.
REQ-036 LW x5,0(x0) (0x00002283) then ADD x6,x5,x0 (0x00028333) back-to-back -> decode_stall_req high exactly one cycle, next_clk_en low one cycle, then ADD decoded with rs1=5, rd=6.
REQ-037 Valid stream with flush=1 for one cycle (stall=1 simultaneously) -> next_clk_en=0 next cycle, fields unchanged, decode_stall_req=0.
REQ-038 0xFFFFFFFF -> with DECODE_ILLEGAL_TRAP_EN: decode_illegal=1, rd=0; without: decode_illegal=0, rd=0.
REQ-039 rst asserted mid-stream between clock edges -> all outputs 0 before the next rising edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions.
// Contents:
//   OPC_*       7-bit major opcode constants
//   imm_fmt_e   immediate format selector (IMM_I/S/B/U/J/NONE)
//   imm_fmt_of  opcode -> immediate format
//   opcode_legal, uses_rs1, uses_rs2  opcode classification helpers
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: return IMM_I;
      OPC_STORE:                                  return IMM_S;
      OPC_BRANCH:                                 return IMM_B;
      OPC_LUI, OPC_AUIPC:                         return IMM_U;
      OPC_JAL:                                    return IMM_J;
      default:                                    return IMM_NONE;
    endcase
  endfunction

  // Every listed opcode ends in 2'b11, so a compressed-style encoding
  // (instr[1:0] != 2'b11) never matches and is illegal.
  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_BRANCH, OPC_STORE, OPC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute bundle for decode_stage.
// Handshake: the fetch side presents fetch_instr/pc with clk_en=1 when it holds
// a valid instruction; it must keep presenting the same instruction while
// decode_stall_req=1. Decode outputs are valid for execute when next_clk_en=1;
// stall holds them, flush kills the instruction entering decode.
// Modports: slave = decode_stage, master = the surrounding pipeline.
interface decode_stage_if;
  logic [31:0] fetch_instr;
  logic [31:0] pc;
  logic        clk_en;
  logic        stall;
  logic        flush;
  logic [31:0] decode_pc;
  logic [6:0]  decode_opcode;
  logic [2:0]  decode_funct3;
  logic        decode_funct7_b5;
  logic [4:0]  decode_rs1_addr;
  logic [4:0]  decode_rs2_addr;
  logic [4:0]  decode_rd_addr;
  logic [31:0] decode_imm;
  logic        decode_illegal;
  logic        next_clk_en;
  logic        decode_stall_req;

  modport slave (
    input  fetch_instr, pc, clk_en, stall, flush,
    output decode_pc, decode_opcode, decode_funct3, decode_funct7_b5,
           decode_rs1_addr, decode_rs2_addr, decode_rd_addr, decode_imm,
           decode_illegal, next_clk_en, decode_stall_req
  );

  modport master (
    output fetch_instr, pc, clk_en, stall, flush,
    input  decode_pc, decode_opcode, decode_funct3, decode_funct7_b5,
           decode_rs1_addr, decode_rs2_addr, decode_rd_addr, decode_imm,
           decode_illegal, next_clk_en, decode_stall_req
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator.
// Ports: instr (in, 32) raw instruction; imm (out, 32) sign-extended immediate,
// zero for opcodes without an immediate format.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_fmt_of(instr[6:0]))
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage with load-use hazard detection.
// Ports: clk, rst (async, active-high); bus (decode_stage_if.slave) carrying
// the fetch inputs, registered decode fields, next_clk_en and the
// combinational decode_stall_req.
// Optional build macro DECODE_ILLEGAL_TRAP_EN: registers decode_illegal;
// otherwise decode_illegal is tied 0.
module decode_stage
  import rv32i_pkg::*;
(
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  logic [6:0]  opc;
  logic        legal;
  logic [4:0]  rd_next;
  logic [4:0]  rs1_next;
  logic [4:0]  rs2_next;
  logic [31:0] imm_next;
  logic        hazard;

  logic [31:0] pc_q;
  logic [6:0]  opc_q;
  logic [2:0]  funct3_q;
  logic        funct7_b5_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic [31:0] imm_q;
  logic        valid_q;

  assign opc   = bus.fetch_instr[6:0];
  assign legal = opcode_legal(opc);

  // Instructions that write no register report rd=0 so downstream
  // writeback and the hazard check below never see a phantom destination.
  assign rd_next  = (legal && opc != OPC_STORE && opc != OPC_BRANCH && opc != OPC_FENCE)
                    ? bus.fetch_instr[11:7] : 5'd0;
  assign rs1_next = uses_rs1(opc) ? bus.fetch_instr[19:15] : 5'd0;
  assign rs2_next = uses_rs2(opc) ? bus.fetch_instr[24:20] : 5'd0;

  imm_gen u_imm_gen (
    .instr (bus.fetch_instr),
    .imm   (imm_next)
  );

  // Load-use: the load in decode produces its data too late for an
  // instruction entering now that reads the same register.
  assign hazard = !rst && valid_q && opc_q == OPC_LOAD && rd_q != 5'd0 && bus.clk_en &&
                  ((uses_rs1(opc) && bus.fetch_instr[19:15] == rd_q) ||
                   (uses_rs2(opc) && bus.fetch_instr[24:20] == rd_q));

  assign bus.decode_stall_req = hazard && !bus.flush;

  wire capture = !bus.flush && !bus.stall && !hazard && bus.clk_en;

  // valid priority: flush kills, stall holds, hazard/no-input make a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q <= capture;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      opc_q       <= '0;
      funct3_q    <= '0;
      funct7_b5_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
    end else if (capture) begin
      pc_q        <= bus.pc;
      opc_q       <= opc;
      funct3_q    <= bus.fetch_instr[14:12];
      funct7_b5_q <= bus.fetch_instr[30];
      rs1_q       <= rs1_next;
      rs2_q       <= rs2_next;
      rd_q        <= rd_next;
      imm_q       <= imm_next;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (capture) begin
      illegal_q <= !legal;
    end
  end
  assign bus.decode_illegal = illegal_q;
`else
  assign bus.decode_illegal = 1'b0;
`endif

  assign bus.decode_pc        = pc_q;
  assign bus.decode_opcode    = opc_q;
  assign bus.decode_funct3    = funct3_q;
  assign bus.decode_funct7_b5 = funct7_b5_q;
  assign bus.decode_rs1_addr  = rs1_q;
  assign bus.decode_rs2_addr  = rs2_q;
  assign bus.decode_rd_addr   = rd_q;
  assign bus.decode_imm       = imm_q;
  assign bus.next_clk_en      = valid_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;

  decode_stage_if bus();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic ILL_ON = 1'b1;
`else
  localparam logic ILL_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic ce, input logic st, input logic fl);
    bus.fetch_instr = instr;
    bus.pc          = pc;
    bus.clk_en      = ce;
    bus.stall       = st;
    bus.flush       = fl;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pc"},   bus.decode_pc, 32'h0);
    check({tag, "_op"},   {25'h0, bus.decode_opcode}, 32'h0);
    check({tag, "_f3"},   {29'h0, bus.decode_funct3}, 32'h0);
    check({tag, "_f7"},   {31'h0, bus.decode_funct7_b5}, 32'h0);
    check({tag, "_rs1"},  {27'h0, bus.decode_rs1_addr}, 32'h0);
    check({tag, "_rs2"},  {27'h0, bus.decode_rs2_addr}, 32'h0);
    check({tag, "_rd"},   {27'h0, bus.decode_rd_addr}, 32'h0);
    check({tag, "_imm"},  bus.decode_imm, 32'h0);
    check({tag, "_ill"},  {31'h0, bus.decode_illegal}, 32'h0);
    check({tag, "_vld"},  {31'h0, bus.next_clk_en}, 32'h0);
    check({tag, "_sreq"}, {31'h0, bus.decode_stall_req}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            instr         op     f3    f7    rd     rs1    rs2    imm           ill
    vecs[0]  = '{32'h00500093, 7'h13, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000005, 1'b0};  // ADDI x1,x0,5
    vecs[1]  = '{32'hFE000EE3, 7'h63, 3'd0, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFC, 1'b0};  // BEQ x0,x0,-4
    vecs[2]  = '{32'h12345137, 7'h37, 3'd5, 1'b0, 5'd2,  5'd0,  5'd0,  32'h12345000, 1'b0};  // LUI x2
    vecs[3]  = '{32'hFE312C23, 7'h23, 3'd2, 1'b1, 5'd0,  5'd2,  5'd3,  32'hFFFFFFF8, 1'b0};  // SW x3,-8(x2)
    vecs[4]  = '{32'h001000EF, 7'h6F, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000800, 1'b0};  // JAL x1,+2048
    vecs[5]  = '{32'h406283B3, 7'h33, 3'd0, 1'b1, 5'd7,  5'd5,  5'd6,  32'h00000000, 1'b0};  // SUB x7,x5,x6
    vecs[6]  = '{32'hFFF081E7, 7'h67, 3'd0, 1'b1, 5'd3,  5'd1,  5'd0,  32'hFFFFFFFF, 1'b0};  // JALR x3,-1(x1)
    vecs[7]  = '{32'h80000217, 7'h17, 3'd0, 1'b0, 5'd4,  5'd0,  5'd0,  32'h80000000, 1'b0};  // AUIPC x4
    vecs[8]  = '{32'h0FF0008F, 7'h0F, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0};  // FENCE, rd field 1
    vecs[9]  = '{32'h123092F3, 7'h73, 3'd1, 1'b0, 5'd5,  5'd0,  5'd0,  32'h00000123, 1'b0};  // CSRRW x5
    vecs[10] = '{32'hFFFFFFFF, 7'h7F, 3'd7, 1'b1, 5'd0,  5'd0,  5'd0,  32'h00000000, ILL_ON}; // all ones
    vecs[11] = '{32'h00500092, 7'h12, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, ILL_ON}; // low bits 10
    vecs[12] = '{32'h00002283, 7'h03, 3'd2, 1'b0, 5'd5,  5'd0,  5'd0,  32'h00000000, 1'b0};  // LW x5,0(x0)

    // Reset is visible before any clock edge.
    rst = 1'b1;
    drive(32'h00500093, 32'h0, 1'b1, 1'b0, 1'b0);
    #3;
    check_zero("rst_init");
    @(negedge clk);
    @(negedge clk);
    check({"rst_held_vld"}, {31'h0, bus.next_clk_en}, 32'h0);
    rst = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Table: capture each vector, then a bubble cycle that must hold fields.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].instr, 32'h1000 + 32'(i) * 4, 1'b1, 1'b0, 1'b0);
      step();
      check($sformatf("v%0d_vld", i), {31'h0, bus.next_clk_en}, 32'h1);
      check($sformatf("v%0d_pc", i),  bus.decode_pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_op", i),  {25'h0, bus.decode_opcode}, {25'h0, vecs[i].op});
      check($sformatf("v%0d_f3", i),  {29'h0, bus.decode_funct3}, {29'h0, vecs[i].f3});
      check($sformatf("v%0d_f7", i),  {31'h0, bus.decode_funct7_b5}, {31'h0, vecs[i].f7});
      check($sformatf("v%0d_rd", i),  {27'h0, bus.decode_rd_addr}, {27'h0, vecs[i].rd});
      check($sformatf("v%0d_rs1", i), {27'h0, bus.decode_rs1_addr}, {27'h0, vecs[i].rs1});
      check($sformatf("v%0d_rs2", i), {27'h0, bus.decode_rs2_addr}, {27'h0, vecs[i].rs2});
      check($sformatf("v%0d_imm", i), bus.decode_imm, vecs[i].imm);
      check($sformatf("v%0d_ill", i), {31'h0, bus.decode_illegal}, {31'h0, vecs[i].ill});
      drive(32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      check($sformatf("v%0d_bub_vld", i), {31'h0, bus.next_clk_en}, 32'h0);
      check($sformatf("v%0d_bub_pc", i),  bus.decode_pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_bub_imm", i), bus.decode_imm, vecs[i].imm);
    end

    // Load-use: LW x5 then ADD x6,x5,x0; fetch holds ADD while stall_req=1.
    drive(32'h00002283, 32'h2000, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_pre_sreq", {31'h0, bus.decode_stall_req}, 32'h0);
    step();
    drive(32'h00028333, 32'h2004, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_sreq_hi", {31'h0, bus.decode_stall_req}, 32'h1);
    step();
    check("lu_bubble_vld", {31'h0, bus.next_clk_en}, 32'h0);
    check("lu_bubble_rd", {27'h0, bus.decode_rd_addr}, 32'd5);
    #1;
    check("lu_sreq_lo", {31'h0, bus.decode_stall_req}, 32'h0);
    step();
    check("lu_add_vld", {31'h0, bus.next_clk_en}, 32'h1);
    check("lu_add_rs1", {27'h0, bus.decode_rs1_addr}, 32'd5);
    check("lu_add_rd",  {27'h0, bus.decode_rd_addr}, 32'd6);
    check("lu_add_pc",  bus.decode_pc, 32'h2004);
    #1;
    check("lu_after_sreq", {31'h0, bus.decode_stall_req}, 32'h0);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // LW to x0 never causes a hazard.
    drive(32'h00002003, 32'h2100, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h00000033, 32'h2104, 1'b1, 1'b0, 1'b0);
    #1;
    check("x0_sreq", {31'h0, bus.decode_stall_req}, 32'h0);
    step();
    check("x0_vld", {31'h0, bus.next_clk_en}, 32'h1);
    check("x0_op", {25'h0, bus.decode_opcode}, 32'h33);

    // Stall holds a valid instruction, next_clk_en included.
    drive(32'h00500093, 32'h3000, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'hFE000EE3, 32'h3004, 1'b1, 1'b1, 1'b0);
    step();
    check("stall_vld", {31'h0, bus.next_clk_en}, 32'h1);
    check("stall_op",  {25'h0, bus.decode_opcode}, 32'h13);
    check("stall_pc",  bus.decode_pc, 32'h3000);

    // Flush with stall: kill, fields unchanged, no stall request.
    drive(32'hFE000EE3, 32'h3004, 1'b1, 1'b1, 1'b1);
    #1;
    check("flush_sreq", {31'h0, bus.decode_stall_req}, 32'h0);
    step();
    check("flush_vld", {31'h0, bus.next_clk_en}, 32'h0);
    check("flush_op",  {25'h0, bus.decode_opcode}, 32'h13);
    check("flush_imm", bus.decode_imm, 32'h5);

    // Flush overrides a load-use hazard.
    drive(32'h00002283, 32'h3100, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h00028333, 32'h3104, 1'b1, 1'b0, 1'b1);
    #1;
    check("flhz_sreq", {31'h0, bus.decode_stall_req}, 32'h0);
    step();
    check("flhz_vld", {31'h0, bus.next_clk_en}, 32'h0);
    check("flhz_rd",  {27'h0, bus.decode_rd_addr}, 32'd5);

    // Asynchronous reset mid-stream, checked before the next rising edge.
    drive(32'h00500093, 32'h4000, 1'b1, 1'b0, 1'b0);
    step();
    check("arst_pre_vld", {31'h0, bus.next_clk_en}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    drive(32'hFE000EE3, 32'h4004, 1'b1, 1'b0, 1'b0);
    step();
    check("post_rst_vld", {31'h0, bus.next_clk_en}, 32'h1);
    check("post_rst_imm", bus.decode_imm, 32'hFFFFFFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
